nes_uart_port: RTL and testbench

Byte-level UART bridge between the host PC and the NES top-level controller. It receives a full NROM cartridge image (16-byte iNES header + PRG + CHR) into an internal receive buffer. The buffer is randomly readable by pointer. It also transmits status characters ('S'/'F') requested by the controller FSM. It runs in the PPU clock domain and sits between the board UART pins and the cartridge-loading FSM.

---
 rtl/nes_uart_port.sv | 170 +++++++++++++++++
 tb/tb_nes_uart_port.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_uart_port.sv
// nes_uart_port: 8N1 UART bridge. Received bytes go into a buffer that can be read at any address; the transmitter sends bytes on request.
// Ports: clk/rst (sync, active-high); uart_port_DI/uart_port_DO serial lines;
//   rx_clear, read_ptr -> uart_DO (1-clk RAM read), read_valid once byte VALID_LAST is stored;
//   tx_clear, send_ptr, tx_DI -> send_done when idle and every requested byte has been sent.
// Optional: define NES_UART_FRAMING_CHECK_EN to drop bytes whose stop bit samples low.
module nes_uart_port #(
  parameter int CLK_FREQ   = 21_477_272,
  parameter int BAUD       = 115_200,
  parameter int RX_DEPTH   = 'h6010,
  parameter int VALID_LAST = 'h600F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_port_DI,
  output logic        uart_port_DO,
  input  logic        rx_clear,
  input  logic [15:0] read_ptr,
  output logic [7:0]  uart_DO,
  output logic        read_valid,
  input  logic        tx_clear,
  input  logic [15:0] send_ptr,
  input  logic [7:0]  tx_DI,
  output logic        send_done
);
  localparam int CPB = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam logic [15:0] BIT_END  = 16'(CPB - 1);
  localparam logic [15:0] HALF_END = 16'(CPB / 2 - 1);
  localparam logic [15:0] DEPTH    = 16'(RX_DEPTH);
  localparam logic [15:0] LAST     = 16'(VALID_LAST);
  localparam int AW = RX_DEPTH > 1 ? $clog2(RX_DEPTH) : 1;

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_st_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_st_t;

  logic sync1_q, sync2_q, prev_q;
  rx_st_t rx_st_q, rx_st_d;
  logic [15:0] rx_cnt_q, rx_cnt_d, rx_count_q, rx_count_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic read_valid_q, read_valid_d, rx_store, rx_we;
  tx_st_t tx_st_q, tx_st_d;
  logic [15:0] tx_cnt_q, tx_cnt_d, sent_q, sent_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic send_done_q, send_done_d, tx_fin;
  logic [7:0] mem [RX_DEPTH];
  logic [7:0] uart_do_q;

  always_comb begin
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_cnt_q + 16'd1;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_store = 1'b0;
    case (rx_st_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (prev_q && !sync2_q) rx_st_d = R_START;
      end
      R_START: if (rx_cnt_q == HALF_END) begin
        rx_cnt_d = '0;
        rx_bit_d = '0;
        rx_st_d = sync2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (rx_cnt_q == BIT_END) begin
        rx_cnt_d = '0;
        rx_sh_d = {sync2_q, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = R_STOP;
      end
      R_STOP: if (rx_cnt_q == BIT_END) begin
`ifdef NES_UART_FRAMING_CHECK_EN
        rx_store = sync2_q;
        rx_st_d = sync2_q ? R_IDLE : R_WAIT;
`else
        rx_store = 1'b1;
        rx_st_d = R_IDLE;
`endif
      end
      R_WAIT: if (sync2_q) rx_st_d = R_IDLE;
      default: rx_st_d = R_IDLE;
    endcase
    // clear beats a byte completing in the same cycle; a full buffer drops bytes
    rx_we = rx_store && !rx_clear && !rst && rx_count_q < DEPTH;
    rx_count_d = rx_clear ? '0 : rx_count_q + {15'd0, rx_we};
    read_valid_d = !rx_clear && rx_count_q > LAST;
  end

  always_comb begin
    tx_st_d = tx_st_q;
    tx_cnt_d = tx_cnt_q + 16'd1;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_fin = 1'b0;
    case (tx_st_q)
      T_IDLE: begin
        tx_cnt_d = '0;
        tx_bit_d = '0;
        if (sent_q < send_ptr) begin
          tx_sh_d = tx_DI;
          tx_st_d = T_START;
        end
      end
      T_START: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        tx_st_d = T_DATA;
      end
      T_DATA: if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        tx_sh_d = {1'b0, tx_sh_q[7:1]};
        tx_bit_d = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_st_d = T_STOP;
      end
      T_STOP: if (tx_cnt_q == BIT_END) begin
        tx_fin = 1'b1;
        tx_st_d = T_IDLE;
      end
      default: tx_st_d = T_IDLE;
    endcase
    sent_d = tx_clear ? '0 : sent_q + {15'd0, tx_fin};
    send_done_d = tx_st_q == T_IDLE && sent_q >= send_ptr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q <= 1'b1;
      rx_st_q <= R_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_count_q <= '0;
      read_valid_q <= 1'b0;
      tx_st_q <= T_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      sent_q <= '0;
      send_done_q <= 1'b1;
    end else begin
      sync1_q <= uart_port_DI;
      sync2_q <= sync1_q;
      prev_q <= sync2_q;
      rx_st_q <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_count_q <= rx_count_d;
      read_valid_q <= read_valid_d;
      tx_st_q <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      sent_q <= sent_d;
      send_done_q <= send_done_d;
    end
  end

  // buffer kept in its own block without reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (rx_we) mem[rx_count_q[AW-1:0]] <= rx_sh_q;
    uart_do_q <= (rst || read_ptr >= DEPTH) ? 8'h00 : mem[read_ptr[AW-1:0]];
  end

  assign uart_DO = uart_do_q;
  assign read_valid = read_valid_q;
  assign send_done = send_done_q;
  assign uart_port_DO = tx_st_q == T_START ? 1'b0 : tx_st_q == T_DATA ? tx_sh_q[0] : 1'b1;
endmodule

// File: tb/tb_nes_uart_port.sv
// tb_nes_uart_port: scoreboard bench for nes_uart_port at 16 clks per bit, 8-byte buffer.
module tb_nes_uart_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic di = 1'b1;
  logic rx_clear = 1'b0;
  logic tx_clear = 1'b0;
  logic [15:0] read_ptr = 16'hFFFF;
  logic [15:0] send_ptr = 16'd0;
  logic [7:0] tx_DI = 8'h00;
  logic [7:0] uart_DO;
  logic do_line, read_valid, send_done;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string nm;
    int sig;
    logic [7:0] val;
    int due;
  } exp_t;
  exp_t exp_q[$];
  logic [7:0] tx_q[$];

  nes_uart_port #(
    .CLK_FREQ(1_600_000),
    .BAUD(100_000),
    .RX_DEPTH(8),
    .VALID_LAST(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_port_DI(di),
    .uart_port_DO(do_line),
    .rx_clear(rx_clear),
    .read_ptr(read_ptr),
    .uart_DO(uart_DO),
    .read_valid(read_valid),
    .tx_clear(tx_clear),
    .send_ptr(send_ptr),
    .tx_DI(tx_DI),
    .send_done(send_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] act_of(input int s);
    return s == 0 ? uart_DO : s == 1 ? {7'd0, read_valid} : s == 2 ? {7'd0, send_done} : {7'd0, do_line};
  endfunction

  task automatic expect_sig(input string nm, input int sig, input logic [7:0] val, input int dly);
    exp_t e;
    e.nm = nm;
    e.sig = sig;
    e.val = val;
    e.due = cyc + dly;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      di = f[i];
      tick(16);
    end
    di = 1'b1;
  endtask

  task automatic rd(input logic [15:0] p, input logic [7:0] v, input string nm);
    read_ptr = p;
    expect_sig(nm, 0, v, 1);
    tick(1);
  endtask

  // status/read scoreboard: compares every entry that has come due
  initial forever begin
    logic [7:0] act;
    @(negedge clk);
    for (int i = 0; i < exp_q.size(); ) begin
      if (exp_q[i].due <= cyc) begin
        act = act_of(exp_q[i].sig);
        n_cmp++;
        if (exp_q[i].due != cyc || act !== exp_q[i].val) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", exp_q[i].nm, act, exp_q[i].val, cyc);
        end
        exp_q.delete(i);
      end else i++;
    end
  end

  // serial frame monitor on the TX line, sampling near each bit centre
  initial begin
    logic act, prev;
    int cnt;
    logic [9:0] bits;
    logic [7:0] e;
    act = 1'b0;
    prev = 1'b1;
    cnt = 0;
    bits = '0;
    forever begin
      @(negedge clk);
      if (rst) act = 1'b0;
      else if (!act) begin
        if (prev && !do_line) begin
          act = 1'b1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt % 16 == 7) begin
          bits[cnt / 16] = do_line;
          if (cnt / 16 == 9) begin
            act = 1'b0;
            n_cmp++;
            if (tx_q.size() == 0) begin
              n_bad++;
              $display("FAIL tx_frame: got %b expected no frame", bits);
            end else begin
              e = tx_q.pop_front();
              if (bits !== {1'b1, e, 1'b0}) begin
                n_bad++;
                $display("FAIL tx_frame: got %b expected %b", bits, {1'b1, e, 1'b0});
              end
            end
          end
        end
      end
      prev = do_line;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end (compared %0d)", n_cmp);
    $fatal(1);
  end

  initial begin
    tick(3);
    expect_sig("rst_uart_DO", 0, 8'h00, 1);
    expect_sig("rst_line", 3, 8'h01, 1);
    expect_sig("rst_read_valid", 1, 8'h00, 1);
    expect_sig("rst_send_done", 2, 8'h01, 1);
    tick(2);
    rst = 1'b0;
    tick(2);
    expect_sig("idle_uart_DO", 0, 8'h00, 1);
    expect_sig("idle_line", 3, 8'h01, 1);
    expect_sig("idle_read_valid", 1, 8'h00, 1);
    expect_sig("idle_send_done", 2, 8'h01, 1);
    tick(3);
    send_byte(8'h4E, 1'b1);
    send_byte(8'h45, 1'b1);
    send_byte(8'h53, 1'b1);
    expect_sig("rv_after3", 1, 8'h00, 1);
    send_byte(8'h1A, 1'b1);
    expect_sig("rv_after4", 1, 8'h01, 1);
    tick(1);
    rd(16'd0, 8'h4E, "rd0");
    rd(16'd1, 8'h45, "rd1");
    rd(16'd2, 8'h53, "rd2");
    rd(16'd3, 8'h1A, "rd3");
    rx_clear = 1'b1;
    expect_sig("rv_clear", 1, 8'h00, 1);
    tick(1);
    rx_clear = 1'b0;
    rd(16'd0, 8'h4E, "keep0");
    send_byte(8'h11, 1'b1);
    expect_sig("rv_one", 1, 8'h00, 1);
    rd(16'd0, 8'h11, "over0");
    rd(16'd1, 8'h45, "keep1");
    send_byte(8'hAA, 1'b0);
    tick(4);
    send_byte(8'h5A, 1'b1);
    tick(1);
`ifdef NES_UART_FRAMING_CHECK_EN
    rd(16'd1, 8'h5A, "ferr_next");
`else
    rd(16'd1, 8'hAA, "ferr_kept");
    rd(16'd2, 8'h5A, "ferr_next");
`endif
    rx_clear = 1'b1;
    tick(1);
    rx_clear = 1'b0;
    for (int i = 0; i < 9; i++) send_byte(8'h30 + 8'(i), 1'b1);
    expect_sig("rv_full", 1, 8'h01, 1);
    tick(1);
    for (int i = 0; i < 8; i++) rd(16'(i), 8'h30 + 8'(i), "sat_rd");
    rd(16'd8, 8'h00, "oob8");
    rd(16'hFFFF, 8'h00, "oob_max");
    tx_clear = 1'b1;
    tx_DI = 8'h53;
    send_ptr = 16'd1;
    tx_q.push_back(8'h53);
    expect_sig("tx_start_line", 3, 8'h00, 1);
    expect_sig("sd_low", 2, 8'h00, 2);
    tick(1);
    tx_clear = 1'b0;
    expect_sig("sd_in_stop", 2, 8'h00, 160);
    expect_sig("sd_after_stop", 2, 8'h01, 161);
    tick(165);
    tx_DI = 8'hA5;
    send_ptr = 16'd2;
    tx_q.push_back(8'hA5);
    tick(170);
    expect_sig("sd_after2", 2, 8'h01, 1);
    tick(1);
    send_ptr = 16'd0;
    tx_DI = 8'hFF;
    expect_sig("sd_ptr_low", 2, 8'h01, 2);
    expect_sig("line_ptr_low", 3, 8'h01, 2);
    tick(20);
    tx_clear = 1'b1;
    tx_DI = 8'h00;
    send_ptr = 16'd1;
    tick(1);
    tx_clear = 1'b0;
    tick(49);
    expect_sig("tx_mid_line", 3, 8'h00, 1);
    expect_sig("tx_mid_sd", 2, 8'h00, 1);
    tick(1);
    rst = 1'b1;
    send_ptr = 16'd0;
    expect_sig("rst_mid_line", 3, 8'h01, 1);
    expect_sig("rst_mid_sd", 2, 8'h01, 1);
    tick(3);
    rst = 1'b0;
    tick(5);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    if (tx_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tx_drain: got %0d frames missing expected 0", tx_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
